// File: rtl/geofence_sched.sv
// geofence_sched: arbitrates four point-stream requesters onto one geofence
// engine. A job is 7 (X,Y) beats (object, then 6 fence vertices) that are
// buffered, replayed to the engine after a one-cycle engine reset, and the
// engine's inside/outside verdict (or a timeout) is returned to the owner.
//
// Handshakes: a beat moves on req_valid[i] & req_ready[i] at a rising edge;
// a result moves on res_valid & res_ready at a rising edge. Valid may be
// raised at any time; once res_valid is high the result fields hold until
// the accepting edge.
module geofence_sched #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [39:0] req_X,
    input  logic [39:0] req_Y,
    output logic [3:0]  req_ready,
    output logic        eng_reset,
    output logic [9:0]  eng_X,
    output logic [9:0]  eng_Y,
    input  logic        eng_valid,
    input  logic        eng_is_inside,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_id,
    output logic        res_inside,
    output logic        res_timeout,
    output logic        busy
);

    // WAIT counts 0..TIMEOUT-1; the job times out in the cycle holding TIMEOUT-1.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    LAST_BEAT = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ERST   = 3'd2,
        STREAM = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    // state is kept as a plain named signal so checkers can bind to it.
    state_t          state;
    state_t          next_state;
    logic [1:0]      grant_id;
    logic [1:0]      rr_ptr;
    logic [1:0]      winner;
    logic [2:0]      beat_cnt;
    logic [2:0]      strm_cnt;
    logic [CW-1:0]   wait_cnt;
    logic [9:0]      buf_x [0:6];
    logic [9:0]      buf_y [0:6];
    logic [9:0]      sel_x;
    logic [9:0]      sel_y;
    logic            beat_xfer;
    logic            wait_expire;
    logic            res_inside_q;
    logic            res_timeout_q;

    // Round-robin pick: scan from rr_ptr upward, the first valid line wins.
    always_comb begin
        winner = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req_valid[rr_ptr + 2'(i)]) begin
                winner = rr_ptr + 2'(i);
            end
        end
    end

    // Data lanes of the granted requester and the beat / timeout qualifiers.
    always_comb begin
        sel_x       = req_X[grant_id*10 +: 10];
        sel_y       = req_Y[grant_id*10 +: 10];
        beat_xfer   = (state == LOAD) && req_valid[grant_id];
        wait_expire = (state == WAIT) && !eng_valid && (wait_cnt == WAIT_LAST);
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        next_state = state;
        req_ready  = 4'b0000;
        eng_X      = 10'd0;
        eng_Y      = 10'd0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                req_ready = 4'b0001 << grant_id;
                if (beat_xfer && (beat_cnt == LAST_BEAT)) begin
                    next_state = ERST;
                end
            end
            ERST: begin
                next_state = STREAM;
            end
            STREAM: begin
                eng_X = buf_x[strm_cnt];
                eng_Y = buf_y[strm_cnt];
                if (strm_cnt == LAST_BEAT) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (eng_valid || wait_expire) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register, counters, grant bookkeeping and the result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_id      <= 2'd0;
            rr_ptr        <= 2'd0;
            beat_cnt      <= 3'd0;
            strm_cnt      <= 3'd0;
            wait_cnt      <= '0;
            res_inside_q  <= 1'b0;
            res_timeout_q <= 1'b0;
            eng_reset     <= 1'b1;
        end else begin
            state <= next_state;
            // Engine reset is high for the ERST cycle, and for the first RESP
            // cycle after a timeout so a hung engine is cleared.
            eng_reset <= (next_state == ERST) || wait_expire;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= winner;
                        rr_ptr   <= winner + 2'd1;
                        beat_cnt <= 3'd0;
                    end
                end
                LOAD: begin
                    if (beat_xfer) begin
                        beat_cnt <= beat_cnt + 3'd1;
                    end
                end
                ERST: begin
                    strm_cnt <= 3'd0;
                end
                STREAM: begin
                    strm_cnt <= strm_cnt + 3'd1;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (eng_valid) begin
                        res_inside_q  <= eng_is_inside;
                        res_timeout_q <= 1'b0;
                    end else if (wait_expire) begin
                        res_inside_q  <= 1'b0;
                        res_timeout_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beat buffer; contents are only meaningful after a full LOAD, so no reset.
    always_ff @(posedge clk) begin
        if (beat_xfer) begin
            buf_x[beat_cnt] <= sel_x;
            buf_y[beat_cnt] <= sel_y;
        end
    end

    // Result and status outputs.
    always_comb begin
        res_valid   = (state == RESP);
        res_id      = grant_id;
        res_inside  = res_inside_q;
        res_timeout = res_timeout_q;
        busy        = (state != IDLE);
    end

endmodule
